// File: rtl/dac_jesd204_pattern_gen_pkg.sv
// Shared constants for the JESD204 DAC pattern generator: source select codes
// and the (order, tap) pair of each PN polynomial.
package dac_jesd204_pattern_gen_pkg;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned PAT_W   = 32;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned UFCNT_W = 16;

    localparam logic [SEL_W-1:0] SEL_DDS   = 4'd0;
    localparam logic [SEL_W-1:0] SEL_PAT   = 4'd1;
    localparam logic [SEL_W-1:0] SEL_DMA   = 4'd2;
    localparam logic [SEL_W-1:0] SEL_ZERO  = 4'd3;
    localparam logic [SEL_W-1:0] SEL_NPN7  = 4'd4;
    localparam logic [SEL_W-1:0] SEL_NPN15 = 4'd5;
    localparam logic [SEL_W-1:0] SEL_PN7   = 4'd6;
    localparam logic [SEL_W-1:0] SEL_PN15  = 4'd7;
    localparam logic [SEL_W-1:0] SEL_RAMP  = 4'd8;
    localparam logic [SEL_W-1:0] SEL_PN9   = 4'd9;
    localparam logic [SEL_W-1:0] SEL_PN23  = 4'd10;
    localparam logic [SEL_W-1:0] SEL_PN31  = 4'd11;

    // Polynomial x^ORDER + x^TAP + 1
    localparam int unsigned PN7_ORDER  = 7;
    localparam int unsigned PN7_TAP    = 6;
    localparam int unsigned PN9_ORDER  = 9;
    localparam int unsigned PN9_TAP    = 5;
    localparam int unsigned PN15_ORDER = 15;
    localparam int unsigned PN15_TAP   = 14;
    localparam int unsigned PN23_ORDER = 23;
    localparam int unsigned PN23_TAP   = 18;
    localparam int unsigned PN31_ORDER = 31;
    localparam int unsigned PN31_TAP   = 28;

endpackage

// File: rtl/dac_pn_lfsr.sv
// Free-running Fibonacci LFSR that produces WIDTH bits per cycle.
// Bit k of pn_c is the k-th bit generated from the current state (bit 0 earliest).
module dac_pn_lfsr #(
    parameter int unsigned ORDER = 7,
    parameter int unsigned TAP   = 6,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed,
    input  logic             advance,
    output logic [WIDTH-1:0] pn_c
);

    logic [ORDER-1:0] state_q;
    logic [ORDER-1:0] state_d;
    logic [ORDER-1:0] walk_c;
    logic             fb_c;

    // Unroll WIDTH single-bit steps; walk_c ends as the state after WIDTH shifts.
    always_comb begin
        walk_c = state_q;
        fb_c   = 1'b0;
        pn_c   = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            fb_c    = walk_c[ORDER-1] ^ walk_c[TAP-1];
            pn_c[k] = fb_c;
            walk_c  = {walk_c[ORDER-2:0], fb_c};
        end
    end

    always_comb begin
        state_d = state_q;
        if (seed) begin
            state_d = '1;
        end else if (advance) begin
            state_d = walk_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '1;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/dac_jesd204_pattern_gen.sv
// Per-channel DAC sample source mux (DDS, pattern, DMA, PN, ramp) with one-cycle
// registered output and DMA underflow detection/counting.
module dac_jesd204_pattern_gen
    import dac_jesd204_pattern_gen_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 2,
    parameter int unsigned DATA_PATH_WIDTH = 4,
    parameter int unsigned SAMPLE_WIDTH    = 16
) (
    input  logic                                                   dac_clk,
    input  logic                                                   dac_rst,
    input  logic                                                   dac_sync,
    input  logic [SEL_W*NUM_CHANNELS-1:0]                          dac_data_sel,
    input  logic [PAT_W*NUM_CHANNELS-1:0]                          dac_pat_data,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0]   dds_data,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0]   dma_data,
    input  logic                                                   dma_valid,
    output logic                                                   dma_ready,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0]   dac_data,
    output logic [NUM_CHANNELS-1:0]                                dac_enable,
    input  logic                                                   underflow_clr,
    output logic                                                   dac_underflow,
    output logic [UFCNT_W-1:0]                                     underflow_count
);

    localparam int unsigned CW = DATA_PATH_WIDTH * SAMPLE_WIDTH;
    localparam int unsigned DW = NUM_CHANNELS * CW;

    logic [DW-1:0]           data_d;
    logic [DW-1:0]           data_q;
    logic [NUM_CHANNELS-1:0] enable_d;
    logic [NUM_CHANNELS-1:0] enable_q;
    logic                    underflow_c;
    logic                    underflow_q;
    logic [UFCNT_W-1:0]      count_d;
    logic [UFCNT_W-1:0]      count_q;
    logic [SAMPLE_WIDTH-1:0] ramp_base_d;
    logic [SAMPLE_WIDTH-1:0] ramp_base_q;

    for (genvar c = 0; c < int'(NUM_CHANNELS); c++) begin : g_ch
        logic [SEL_W-1:0] sel_c;
        logic [CW-1:0]    pn7_c;
        logic [CW-1:0]    pn9_c;
        logic [CW-1:0]    pn15_c;
        logic [CW-1:0]    pn23_c;
        logic [CW-1:0]    pn31_c;

        assign sel_c       = dac_data_sel[SEL_W*c +: SEL_W];
        assign enable_d[c] = (sel_c == SEL_DMA);

        dac_pn_lfsr #(.ORDER(PN7_ORDER), .TAP(PN7_TAP), .WIDTH(CW)) u_pn7 (
            .clk(dac_clk), .rst(dac_rst), .seed(dac_sync), .advance(1'b1), .pn_c(pn7_c)
        );
        dac_pn_lfsr #(.ORDER(PN9_ORDER), .TAP(PN9_TAP), .WIDTH(CW)) u_pn9 (
            .clk(dac_clk), .rst(dac_rst), .seed(dac_sync), .advance(1'b1), .pn_c(pn9_c)
        );
        dac_pn_lfsr #(.ORDER(PN15_ORDER), .TAP(PN15_TAP), .WIDTH(CW)) u_pn15 (
            .clk(dac_clk), .rst(dac_rst), .seed(dac_sync), .advance(1'b1), .pn_c(pn15_c)
        );
        dac_pn_lfsr #(.ORDER(PN23_ORDER), .TAP(PN23_TAP), .WIDTH(CW)) u_pn23 (
            .clk(dac_clk), .rst(dac_rst), .seed(dac_sync), .advance(1'b1), .pn_c(pn23_c)
        );
        dac_pn_lfsr #(.ORDER(PN31_ORDER), .TAP(PN31_TAP), .WIDTH(CW)) u_pn31 (
            .clk(dac_clk), .rst(dac_rst), .seed(dac_sync), .advance(1'b1), .pn_c(pn31_c)
        );

        for (genvar l = 0; l < int'(DATA_PATH_WIDTH); l++) begin : g_lane
            localparam int unsigned OFS  = c*CW + l*SAMPLE_WIDTH;
            // PN lanes are reversed so the earliest generated sample lands in the top lane
            localparam int unsigned SWZ  = (DATA_PATH_WIDTH-1-l) * SAMPLE_WIDTH;
            localparam int unsigned POFS = PAT_W*c + WORD_W*(l % 2) + WORD_W - SAMPLE_WIDTH;

            logic [SAMPLE_WIDTH-1:0] lane_d;

            always_comb begin
                lane_d = '0;
                case (sel_c)
                    SEL_DDS:   lane_d = dds_data[OFS +: SAMPLE_WIDTH];
                    SEL_PAT:   lane_d = dac_pat_data[POFS +: SAMPLE_WIDTH];
                    SEL_DMA:   lane_d = dma_valid ? dma_data[OFS +: SAMPLE_WIDTH] : '0;
                    SEL_NPN7:  lane_d = ~pn7_c[SWZ +: SAMPLE_WIDTH];
                    SEL_NPN15: lane_d = ~pn15_c[SWZ +: SAMPLE_WIDTH];
                    SEL_PN7:   lane_d = pn7_c[SWZ +: SAMPLE_WIDTH];
                    SEL_PN15:  lane_d = pn15_c[SWZ +: SAMPLE_WIDTH];
                    SEL_RAMP:  lane_d = ramp_base_q + SAMPLE_WIDTH'(l);
                    SEL_PN9:   lane_d = pn9_c[SWZ +: SAMPLE_WIDTH];
                    SEL_PN23:  lane_d = pn23_c[SWZ +: SAMPLE_WIDTH];
                    SEL_PN31:  lane_d = pn31_c[SWZ +: SAMPLE_WIDTH];
                    default:   lane_d = '0;
                endcase
            end

            assign data_d[OFS +: SAMPLE_WIDTH] = lane_d;
        end
    end

    assign dma_ready   = |enable_d;
    assign underflow_c = dma_ready & ~dma_valid;

    // Clear wins over increment but still records a coincident underflow
    always_comb begin
        count_d     = count_q;
        ramp_base_d = ramp_base_q + SAMPLE_WIDTH'(DATA_PATH_WIDTH);
        if (underflow_clr) begin
            count_d = UFCNT_W'(underflow_c);
        end else if (underflow_c && (count_q != '1)) begin
            count_d = count_q + UFCNT_W'(1);
        end
        if (dac_sync) begin
            ramp_base_d = '0;
        end
    end

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            data_q      <= '0;
            enable_q    <= '0;
            underflow_q <= 1'b0;
            count_q     <= '0;
            ramp_base_q <= '0;
        end else begin
            data_q      <= data_d;
            enable_q    <= enable_d;
            underflow_q <= underflow_c;
            count_q     <= count_d;
            ramp_base_q <= ramp_base_d;
        end
    end

    assign dac_data        = data_q;
    assign dac_enable      = enable_q;
    assign dac_underflow   = underflow_q;
    assign underflow_count = count_q;

endmodule
